// File: rtl/adc_spi_config_master.sv
// rtl/adc_spi_config_master.sv - SPI mode-0 master that writes 16-bit config words to the ADCs and captures the MISO reply
module adc_spi_config_master #(
  parameter int SIZE_BIT         = 16,
  parameter int SIZE_SPI_CS      = 3,
  parameter int SIZE_BIT_COUNTER = 6,
  parameter int CLK_DIV          = 4
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic                   start,
  input  logic [SIZE_SPI_CS-1:0] cs_mask,
  input  logic [SIZE_BIT-1:0]    wr_data,
  output logic                   busy,
  output logic                   done,
  output logic [SIZE_BIT-1:0]    rd_data,
  output logic                   spi_sclk,
  output logic                   spi_mosi,
  output logic [SIZE_SPI_CS-1:0] spi_cs_n,
  input  logic                   spi_miso
);

  typedef enum logic [1:0] {IDLE, SHIFT_LOW, SHIFT_HIGH, HOLD} state_t;

  localparam logic [7:0]                  DIV_LAST = 8'(CLK_DIV - 1);
  localparam logic [SIZE_BIT_COUNTER-1:0] BIT_LAST = SIZE_BIT_COUNTER'(SIZE_BIT - 1);

  state_t                      state, state_next;
  logic [7:0]                  div_cnt, div_cnt_next;
  logic [SIZE_BIT_COUNTER-1:0] bit_cnt, bit_cnt_next;
  logic [SIZE_BIT-1:0]         tx_reg, tx_next;
  logic [SIZE_BIT-1:0]         rx_reg, rx_next;
  logic [SIZE_SPI_CS-1:0]      mask_reg, mask_next;
  logic [SIZE_BIT-1:0]         rd_next;
  logic                        done_next;
  logic                        div_wrap;

  assign div_wrap = (div_cnt == DIV_LAST);

  always_ff @(posedge clk or posedge reset) begin
    if (reset) state <= IDLE;
    else       state <= state_next;
  end

  always_comb begin
    state_next   = state;
    div_cnt_next = div_cnt;
    bit_cnt_next = bit_cnt;
    tx_next      = tx_reg;
    rx_next      = rx_reg;
    mask_next    = mask_reg;
    rd_next      = rd_data;
    done_next    = 1'b0;
    case (state)
      IDLE: begin
        if (start && (|cs_mask)) begin
          tx_next      = wr_data;
          mask_next    = cs_mask;
          bit_cnt_next = BIT_LAST;
          div_cnt_next = 8'd0;
          state_next   = SHIFT_LOW;
        end
      end
      SHIFT_LOW: begin
        if (div_wrap) begin
          div_cnt_next = 8'd0;
          // MISO is captured on the same edge that raises SCLK
          rx_next      = {rx_reg[SIZE_BIT-2:0], spi_miso};
          state_next   = SHIFT_HIGH;
        end else begin
          div_cnt_next = div_cnt + 8'd1;
        end
      end
      SHIFT_HIGH: begin
        if (div_wrap) begin
          div_cnt_next = 8'd0;
          if (bit_cnt == '0) begin
            state_next = HOLD;
          end else begin
            bit_cnt_next = bit_cnt - 1'b1;
            tx_next      = {tx_reg[SIZE_BIT-2:0], 1'b0};
            state_next   = SHIFT_LOW;
          end
        end else begin
          div_cnt_next = div_cnt + 8'd1;
        end
      end
      HOLD: begin
        if (div_wrap) begin
          div_cnt_next = 8'd0;
          done_next    = 1'b1;
          rd_next      = rx_reg;
          state_next   = IDLE;
        end else begin
          div_cnt_next = div_cnt + 8'd1;
        end
      end
      default: state_next = IDLE;
    endcase
  end

  // Pin outputs are registered from the next-state view so they line up with the state
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      div_cnt  <= 8'd0;
      bit_cnt  <= '0;
      tx_reg   <= '0;
      rx_reg   <= '0;
      mask_reg <= '0;
      busy     <= 1'b0;
      done     <= 1'b0;
      rd_data  <= '0;
      spi_sclk <= 1'b0;
      spi_mosi <= 1'b0;
      spi_cs_n <= '1;
    end else begin
      div_cnt  <= div_cnt_next;
      bit_cnt  <= bit_cnt_next;
      tx_reg   <= tx_next;
      rx_reg   <= rx_next;
      mask_reg <= mask_next;
      busy     <= (state_next != IDLE);
      done     <= done_next;
      rd_data  <= rd_next;
      spi_sclk <= (state_next == SHIFT_HIGH);
      spi_mosi <= (state_next == IDLE) ? 1'b0 : tx_next[SIZE_BIT-1];
      spi_cs_n <= (state_next == IDLE) ? '1 : ~mask_next;
    end
  end

endmodule

// File: tb/tb_adc_spi_config_master.sv
// tb/tb_adc_spi_config_master.sv - bench for adc_spi_config_master against a cycle-arithmetic frame model
module tb_adc_spi_config_master;

  logic        clk = 1'b0;
  logic        reset;
  logic        start0, start1;
  logic [2:0]  cs_mask0, cs_mask1;
  logic [15:0] wr_data0, wr_data1;
  logic        busy0, busy1, done0, done1;
  logic [15:0] rd_data0, rd_data1;
  logic        sclk0, sclk1, mosi0, mosi1;
  logic [2:0]  cs_n0, cs_n1;
  logic        miso0;
  logic        miso1 = 1'b1;

  int checks = 0;
  int failures = 0;

  adc_spi_config_master #(.CLK_DIV(4)) dut (
    .clk(clk), .reset(reset), .start(start0), .cs_mask(cs_mask0), .wr_data(wr_data0),
    .busy(busy0), .done(done0), .rd_data(rd_data0), .spi_sclk(sclk0), .spi_mosi(mosi0),
    .spi_cs_n(cs_n0), .spi_miso(miso0)
  );

  adc_spi_config_master #(.CLK_DIV(1)) dut1 (
    .clk(clk), .reset(reset), .start(start1), .cs_mask(cs_mask1), .wr_data(wr_data1),
    .busy(busy1), .done(done1), .rd_data(rd_data1), .spi_sclk(sclk1), .spi_mosi(mosi1),
    .spi_cs_n(cs_n1), .spi_miso(miso1)
  );

  always #5 clk = ~clk;

  // Slave: presents the reply MSB first, advancing on each SCLK falling edge
  logic [15:0] slave_word = 16'h0000;
  logic [4:0]  fall_cnt;
  wire         cs_idle = &cs_n0;
  always @(negedge sclk0 or posedge cs_idle) begin
    if (cs_idle) fall_cnt <= 5'd0;
    else if (fall_cnt != 5'd16) fall_cnt <= fall_cnt + 5'd1;
  end
  assign miso0 = (fall_cnt < 5'd16) ? slave_word[~fall_cnt[3:0]] : 1'b0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0h expected=%0h", name, act, exp);
    end
  endtask

  typedef struct packed {
    logic       busy;
    logic       done;
    logic       sclk;
    logic [2:0] cs_n;
    logic       mosi;
    logic       mcare;
  } exp_t;

  // Expected pins k cycles after the start was accepted, from frame arithmetic
  function automatic exp_t model(int k, int div, logic [15:0] wr, logic [2:0] mask);
    exp_t e;
    int frame = (2 * 16 + 1) * div;
    int ph;
    e = '0;
    e.cs_n = 3'b111;
    if (k >= 1 && k <= frame) begin
      e.busy = 1'b1;
      e.cs_n = ~mask;
      ph = (k - 1) / div;
      if (ph < 32) begin
        e.sclk  = ((ph % 2) == 1);
        e.mosi  = wr[15 - ph / 2];
        e.mcare = 1'b1;
      end
    end else if (k == frame + 1) begin
      e.done = 1'b1;
    end
    return e;
  endfunction

  logic [15:0] last_rd0 = 16'h0000;

  task automatic drive_start(input bit sel, input logic [15:0] wr, input logic [2:0] mask);
    if (!sel) begin start0 = 1'b1; wr_data0 = wr; cs_mask0 = mask; end
    else      begin start1 = 1'b1; wr_data1 = wr; cs_mask1 = mask; end
  endtask

  // Called at a negedge; returns at the negedge of the done cycle (or after an aborting reset)
  task automatic run_frame(input bit sel, input logic [15:0] wr, input logic [2:0] mask,
                           input logic [15:0] mword, input int poke, input int abort,
                           input logic [15:0] exp_rd);
    int div = sel ? 1 : 4;
    int frame = (2 * 16 + 1) * div;
    bit wave_ok = 1'b1;
    int rises = 0;
    logic prev_sclk = 1'b0;
    logic [15:0] got = 16'h0000;
    exp_t e;
    logic [6:0] act_v, exp_v;
    logic ob_busy, ob_done, ob_sclk, ob_mosi;
    logic [2:0] ob_cs;
    if (!sel) slave_word = mword;
    drive_start(sel, wr, mask);
    for (int k = 1; k <= frame + 1; k++) begin
      @(negedge clk);
      if (k == 1) begin start0 = 1'b0; start1 = 1'b0; end
      if (poke != 0 && k == poke) drive_start(1'b0, ~wr, 3'b111);
      if (poke != 0 && k == poke + 1) start0 = 1'b0;
      if (k == abort) begin
        reset = 1'b1;
        #1;
        check("abort_cs_n", cs_n0, 3'b111);
        check("abort_sclk", sclk0, 1'b0);
        check("abort_busy", busy0, 1'b0);
        check("abort_done", done0, 1'b0);
        check("abort_rd_data", rd_data0, 16'h0000);
        @(negedge clk);
        reset = 1'b0;
        last_rd0 = 16'h0000;
        return;
      end
      ob_busy = sel ? busy1 : busy0;
      ob_done = sel ? done1 : done0;
      ob_sclk = sel ? sclk1 : sclk0;
      ob_mosi = sel ? mosi1 : mosi0;
      ob_cs   = sel ? cs_n1 : cs_n0;
      e = model(k, div, wr, mask);
      act_v = {ob_busy, ob_done, ob_sclk, ob_cs, ob_mosi & e.mcare};
      exp_v = {e.busy, e.done, e.sclk, e.cs_n, e.mosi & e.mcare};
      if (wave_ok) begin
        check($sformatf("wave_k%0d", k), 32'(act_v), 32'(exp_v));
        if (act_v !== exp_v) wave_ok = 1'b0;
      end
      if (ob_sclk && !prev_sclk) begin
        got = {got[14:0], ob_mosi};
        rises++;
      end
      prev_sclk = ob_sclk;
    end
    check("mosi_word", got, wr);
    check("sclk_rises", rises, 16);
    check("rd_data", sel ? rd_data1 : rd_data0, exp_rd);
    if (!sel) last_rd0 = exp_rd;
  endtask

  // Start with an empty mask must be ignored; rd_data must hold
  task automatic idle_check(input int n);
    drive_start(1'b0, 16'($urandom), 3'b000);
    for (int k = 1; k <= n; k++) begin
      @(negedge clk);
      start0 = 1'b0;
      check("ignored_start", {busy0, done0, cs_n0}, {1'b0, 1'b0, 3'b111});
      check("rd_hold", rd_data0, last_rd0);
    end
  endtask

  typedef struct {
    bit          sel;
    logic [15:0] wr;
    logic [2:0]  mask;
    logic [15:0] mword;
    int          poke;
    bit          chain;
    logic [15:0] exp_rd;
  } vec_t;

  vec_t tbl[4];

  initial begin
    tbl[0] = '{1'b0, 16'hA55A, 3'b010, 16'h3C81, 0,  1'b1, 16'h3C81};
    tbl[1] = '{1'b0, 16'h0001, 3'b001, 16'h5AA5, 0,  1'b0, 16'h5AA5};
    tbl[2] = '{1'b0, 16'h1234, 3'b100, 16'h0F0F, 50, 1'b0, 16'h0F0F};
    tbl[3] = '{1'b1, 16'hFFFF, 3'b111, 16'h0000, 0,  1'b0, 16'hFFFF};

    reset = 1'b1;
    start0 = 1'b0; cs_mask0 = 3'b000; wr_data0 = 16'h0000;
    start1 = 1'b0; cs_mask1 = 3'b000; wr_data1 = 16'h0000;
    repeat (2) @(negedge clk);
    check("reset_outputs", {busy0, done0, sclk0, mosi0, cs_n0}, {4'b0000, 3'b111});
    check("reset_rd_data", rd_data0, 16'h0000);
    reset = 1'b0;
    @(negedge clk);

    idle_check(4);

    for (int i = 0; i < 4; i++) begin
      run_frame(tbl[i].sel, tbl[i].wr, tbl[i].mask, tbl[i].mword, tbl[i].poke, 0, tbl[i].exp_rd);
      if (!tbl[i].chain) idle_check(3);
    end

    // Reset 40 cycles into a frame, then a clean frame must follow
    run_frame(1'b0, 16'hC3C3, 3'b100, 16'h1111, 0, 40, 16'h1111);
    check("post_abort_rd", rd_data0, 16'h0000);
    idle_check(2);
    run_frame(1'b0, 16'h6E19, 3'b011, 16'h9B27, 0, 0, 16'h9B27);

    for (int r = 0; r < 6; r++) begin
      logic [15:0] w, m;
      logic [2:0] msk;
      int poke;
      w = 16'($urandom);
      m = 16'($urandom);
      msk = 3'($urandom_range(1, 7));
      poke = ($urandom_range(0, 1) == 1) ? $urandom_range(2, 130) : 0;
      slave_word = m;
      run_frame(1'b0, w, msk, m, poke, 0, m);
      if (($urandom_range(0, 1) == 1)) idle_check($urandom_range(1, 4));
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
